// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the simple-dual-port byte-enable RAM.
// Holds the scrub FSM states and the byte-lane merge function.
package sdp_ram_pkg;

  typedef enum logic {
    SCRUB,
    IDLE
  } state_t;

  // Widest data word the merge helper supports.
  localparam int MAXW = 256;

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic logic [MAXW-1:0] be_merge(
    input logic [MAXW-1:0]   old_w,
    input logic [MAXW-1:0]   new_w,
    input logic [MAXW/8-1:0] be
  );
    logic [MAXW-1:0] m;
    m = old_w;
    for (int i = 0; i < MAXW/8; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/sdp_ram_rd_pipe.sv
// Read result delay line of depth LAT with synchronous flush.
// Data registers only load on a valid beat, so the output holds between reads.
module sdp_ram_rd_pipe #(
  parameter int DAT = 32,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [DAT-1:0] in_data,
  output logic           out_valid,
  output logic [DAT-1:0] out_data
);

  logic [LAT-1:0] v;
  logic [DAT-1:0] d [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[LAT-1];
  assign out_data  = d[LAT-1];

endmodule

// File: rtl/sdp_ram_be.sv
// Simple-dual-port RAM with byte enables, scrub engine and error strobe.
// One write port, one pipelined read port, configurable read-during-write.
module sdp_ram_be
  import sdp_ram_pkg::*;
#(
  parameter int ADR      = 8,
  parameter int DAT      = 32,
  parameter int DPTH     = 256,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CS,
  input  logic             WE,
  input  logic [ADR-1:0]   WrAddr,
  input  logic [DAT-1:0]   dataIn,
  input  logic [DAT/8-1:0] BE,
  input  logic             RD,
  input  logic [ADR-1:0]   RdAddr,
  input  logic             Init,
  output logic [DAT-1:0]   dataOut,
  output logic             RdValid,
  output logic             Busy,
  output logic             Err
);

  localparam int AW = (DPTH > 1) ? $clog2(DPTH) : 1;
  localparam logic [ADR:0] LIM = (ADR+1)'(DPTH);
  localparam logic [ADR-1:0] LAST = ADR'(DPTH - 1);

  if (!rd_lat_ok(RD_LAT) || (DAT % 8) != 0 || DAT > MAXW ||
      DPTH < 2 || DPTH > (1 << ADR)) begin : g_bad_param
    $error("sdp_ram_be: illegal parameter set");
  end

  logic [DAT-1:0] mem [DPTH];

  state_t         state;
  logic [ADR-1:0] cnt;

  logic           wr_in;
  logic           rd_in;
  logic           wr_ok;
  logic           rd_ok;
  logic           err_nx;
  logic           same;
  logic [DAT-1:0] wr_word;
  logic [DAT-1:0] rd_word;

  // Extra top bit keeps the compare exact when DPTH == 2**ADR.
  assign wr_in = {1'b0, WrAddr} < LIM;
  assign rd_in = {1'b0, RdAddr} < LIM;

  assign wr_ok = CS & WE & ~Busy & wr_in;
  assign rd_ok = CS & RD & ~Busy & rd_in;

  assign err_nx = CS & ((WE & (Busy | ~wr_in)) |
                        (RD & (Busy | ~rd_in)));

  assign wr_word = DAT'(be_merge(MAXW'(mem[WrAddr[AW-1:0]]),
                                 MAXW'(dataIn),
                                 (MAXW/8)'(BE)));

  assign same = wr_ok & (WrAddr == RdAddr);

  assign rd_word = (RDW_MODE != 0 && same) ? wr_word
                                            : mem[RdAddr[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state == SCRUB) mem[cnt[AW-1:0]] <= '0;
      else if (wr_ok)     mem[WrAddr[AW-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= SCRUB;
      cnt   <= '0;
      Busy  <= 1'b1;
      Err   <= 1'b0;
    end else begin
      Err <= err_nx;
      unique case (state)
        SCRUB: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (Init) begin
            state <= SCRUB;
            cnt   <= '0;
            Busy  <= 1'b1;
          end
        end
        default: begin
          state <= SCRUB;
          cnt   <= '0;
          Busy  <= 1'b1;
        end
      endcase
    end
  end

  sdp_ram_rd_pipe #(
    .DAT (DAT),
    .LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (Clk),
    .rst       (Rst),
    .in_valid  (rd_ok),
    .in_data   (rd_word),
    .out_valid (RdValid),
    .out_data  (dataOut)
  );

endmodule

// File: tb/tb_sdp_ram_be.sv
// Bench for sdp_ram_be: two instances (latency 1 / old-data, latency 2 /
// new-data) driven in lockstep and compared against a word-level model.
module tb_sdp_ram_be;

  logic        Clk = 1'b0;
  logic        Rst, CS, WE, RD, Init;
  logic [3:0]  WrAddr, RdAddr, BE;
  logic [31:0] dataIn;

  logic [31:0] dout0, dout1;
  logic        rv0, rv1, busy0, busy1, err0, err1;

  always #5 Clk = ~Clk;

  sdp_ram_be #(
    .ADR(4), .DAT(32), .DPTH(8), .RD_LAT(1), .RDW_MODE(0)
  ) u0 (
    .Clk(Clk), .Rst(Rst), .CS(CS), .WE(WE), .WrAddr(WrAddr),
    .dataIn(dataIn), .BE(BE), .RD(RD), .RdAddr(RdAddr),
    .Init(Init), .dataOut(dout0), .RdValid(rv0),
    .Busy(busy0), .Err(err0)
  );

  sdp_ram_be #(
    .ADR(4), .DAT(32), .DPTH(8), .RD_LAT(2), .RDW_MODE(1)
  ) u1 (
    .Clk(Clk), .Rst(Rst), .CS(CS), .WE(WE), .WrAddr(WrAddr),
    .dataIn(dataIn), .BE(BE), .RD(RD), .RdAddr(RdAddr),
    .Init(Init), .dataOut(dout1), .RdValid(rv1),
    .Busy(busy1), .Err(err1)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  localparam int LAT [2] = '{1, 2};
  localparam int RDW [2] = '{0, 1};

  int          n_chk = 0;
  int          n_fail = 0;
  int          t = 0;
  logic [31:0] mm [2][8];
  bit          m_busy [2];
  int          m_cnt [2];
  bit          m_err [2];
  bit          m_rv [2];
  logic [31:0] m_hold [2];
  rd_t         q [2][$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0]  be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  // Model one rising edge for instance d using the pre-edge inputs.
  task automatic model(input int d, input bit rst, input bit cs,
                       input bit we, input int wa, input logic [31:0] di,
                       input logic [3:0] be, input bit rd, input int ra,
                       input bit init);
    bit          wok, rok;
    logic [31:0] nv;
    rd_t         r;
    if (rst) begin
      m_busy[d] = 1'b1;
      m_cnt[d]  = 0;
      m_err[d]  = 1'b0;
      m_hold[d] = '0;
      q[d].delete();
    end else begin
      m_err[d] = cs && ((we && (m_busy[d] || wa >= 8)) ||
                        (rd && (m_busy[d] || ra >= 8)));
      wok = cs && we && !m_busy[d] && wa < 8;
      rok = cs && rd && !m_busy[d] && ra < 8;
      nv = wok ? merge(mm[d][wa], di, be) : '0;
      if (rok) begin
        r.due  = t + LAT[d] - 1;
        r.data = (RDW[d] == 1 && wok && wa == ra) ? nv : mm[d][ra];
        q[d].push_back(r);
      end
      if (m_busy[d]) begin
        mm[d][m_cnt[d]] = '0;
        m_cnt[d]++;
        if (m_cnt[d] == 8) m_busy[d] = 1'b0;
      end else begin
        if (wok) mm[d][wa] = nv;
        if (init) begin
          m_busy[d] = 1'b1;
          m_cnt[d]  = 0;
        end
      end
    end
    m_rv[d] = 1'b0;
    if (q[d].size() > 0 && q[d][0].due == t) begin
      m_rv[d]   = 1'b1;
      m_hold[d] = q[d][0].data;
      void'(q[d].pop_front());
    end
  endtask

  task automatic cyc(input bit rst, input bit cs, input bit we,
                     input int wa, input logic [31:0] di,
                     input logic [3:0] be, input bit rd, input int ra,
                     input bit init);
    Rst = rst; CS = cs; WE = we; WrAddr = 4'(wa);
    dataIn = di; BE = be; RD = rd; RdAddr = 4'(ra); Init = init;
    @(posedge Clk);
    t++;
    for (int d = 0; d < 2; d++)
      model(d, rst, cs, we, wa, di, be, rd, ra, init);
    #1;
    chk("rdvalid0", 32'(rv0), 32'(m_rv[0]));
    chk("dout0", dout0, m_hold[0]);
    chk("busy0", 32'(busy0), 32'(m_busy[0]));
    chk("err0", 32'(err0), 32'(m_err[0]));
    chk("rdvalid1", 32'(rv1), 32'(m_rv[1]));
    chk("dout1", dout1, m_hold[1]);
    chk("busy1", 32'(busy1), 32'(m_busy[1]));
    chk("err1", 32'(err1), 32'(m_err[1]));
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, '0, '0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input logic [31:0] v, input logic [3:0] b);
    cyc(0, 1, 1, a, v, b, 0, 0, 0);
  endtask

  task automatic rdq(input int a);
    cyc(0, 1, 0, 0, '0, '0, 1, a, 0);
  endtask

  initial begin
    Rst = 1'b1; CS = 1'b0; WE = 1'b0; RD = 1'b0; Init = 1'b0;
    WrAddr = '0; RdAddr = '0; BE = '0; dataIn = '0;
    @(negedge Clk);
    cyc(1, 1, 1, 0, 32'hdead_beef, 4'hf, 0, 0, 0);
    cyc(1, 0, 0, 0, '0, '0, 0, 0, 0);
    idle(8);
    for (int a = 0; a < 8; a++) rdq(a);
    idle(2);
    wr(3, 32'h1122_3344, 4'b1111);
    wr(3, 32'hAABB_CCDD, 4'b0101);
    rdq(3);
    idle(2);
    wr(2, 32'h1, 4'b1111);
    cyc(0, 1, 1, 2, 32'h5, 4'b1111, 1, 2, 0);
    idle(2);
    wr(9, 32'h77, 4'b1111);
    rdq(12);
    rdq(9);
    idle(2);
    for (int a = 0; a < 4; a++) rdq(a);
    idle(3);
    for (int a = 4; a < 8; a++) rdq(a);
    cyc(1, 0, 0, 0, '0, '0, 0, 0, 0);
    idle(9);
    wr(1, 32'hCAFE_F00D, 4'b1111);
    cyc(0, 1, 0, 0, '0, '0, 0, 0, 1);
    wr(1, 32'h1234_5678, 4'b1111);
    idle(8);
    for (int a = 0; a < 8; a++) rdq(a);
    idle(2);
    cyc(0, 0, 1, 9, '0, 4'hf, 1, 13, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) != 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 9),
          $urandom,
          4'($urandom),
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 9),
          $urandom_range(0, 49) == 0);
    end
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
